// File: rtl/tap_result_fifo.sv
// Buffers tap vectors captured on `found` and drains each one as a bit-serial, MSB-first frame.
// Optional macro TAP_FRAME_CRC_EN appends a CRC-8 (poly 0x07, init 0x00) after the data bits.
module tap_result_fifo #(
  parameter int NUM_OF_TAPS = 15,
  parameter int DEPTH       = 4
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic                         found,
  input  logic [NUM_OF_TAPS*8-1:0]     taps,
  input  logic                         ser_ready,
  output logic                         ser_valid,
  output logic                         ser_dout,
  output logic                         ser_last,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow
);

  localparam int W    = NUM_OF_TAPS * 8;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(W);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

`ifdef TAP_FRAME_CRC_EN
  typedef enum logic [1:0] {IDLE, SHIFT, CRC} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
  localparam logic [CW-1:0] PRE_LAST = CW'(W - 2);
`endif

  state_t          state;
  logic [W-1:0]    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [W-1:0]    shreg;
  logic [CW-1:0]   bitcnt;
  logic            pop;
  logic            push;

  assign full  = (count == CNTW'(DEPTH));
  assign empty = (count == '0);
  // A pop frees a slot on the same edge, so a push into a full FIFO is still accepted then.
  assign pop   = (state == IDLE) && !empty;
  assign push  = found && (!full || pop);
  // The outgoing bit is always the top of the shift register (data, then CRC when enabled).
  assign ser_dout = shreg[W-1];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= taps;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (found && !push) overflow <= 1'b1;
      if (push && !pop)      count <= count + CNTW'(1);
      else if (!push && pop) count <= count - CNTW'(1);
    end
  end

`ifdef TAP_FRAME_CRC_EN
  logic [7:0] crc;
  logic [7:0] crc_next;
  logic       crc_fb;
  assign crc_fb   = crc[7] ^ shreg[W-1];
  assign crc_next = {crc[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
`endif

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state     <= IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
`ifdef TAP_FRAME_CRC_EN
      crc       <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            shreg     <= mem[rd_ptr];
            bitcnt    <= '0;
            state     <= SHIFT;
            ser_valid <= 1'b1;
            ser_last  <= 1'b0;
`ifdef TAP_FRAME_CRC_EN
            crc       <= 8'h00;
`endif
          end
        end
        SHIFT: begin
          if (ser_ready) begin
            bitcnt <= bitcnt + 1'b1;
`ifdef TAP_FRAME_CRC_EN
            crc <= crc_next;
            if (bitcnt == LAST_BIT) begin
              // Load the finished CRC into the top of the shift register for the trailer.
              shreg  <= {crc_next, {(W-8){1'b0}}};
              bitcnt <= '0;
              state  <= CRC;
            end else begin
              shreg <= shreg << 1;
            end
`else
            shreg    <= shreg << 1;
            ser_last <= (bitcnt == PRE_LAST);
            if (bitcnt == LAST_BIT) begin
              state     <= IDLE;
              ser_valid <= 1'b0;
              ser_last  <= 1'b0;
            end
`endif
          end
        end
`ifdef TAP_FRAME_CRC_EN
        CRC: begin
          if (ser_ready) begin
            shreg    <= shreg << 1;
            bitcnt   <= bitcnt + 1'b1;
            ser_last <= (bitcnt == CW'(6));
            if (bitcnt == CW'(7)) begin
              state     <= IDLE;
              ser_valid <= 1'b0;
              ser_last  <= 1'b0;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tap_result_fifo.sv
// Scoreboarded bench for tap_result_fifo: pushed words are queued and compared as frames drain.
// Builds with or without TAP_FRAME_CRC_EN; the expected frame follows the macro.
module tb_tap_result_fifo;
  localparam int NT    = 2;
  localparam int W     = NT * 8;
  localparam int DEPTH = 4;
`ifdef TAP_FRAME_CRC_EN
  localparam int FL = W + 8;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         res = 1'b0;
  logic         found = 1'b0;
  logic [W-1:0] taps = '0;
  logic         ser_ready = 1'b0;
  logic         ser_valid, ser_dout, ser_last;
  logic [2:0]   count;
  logic         full, empty, overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  tap_result_fifo #(.NUM_OF_TAPS(NT), .DEPTH(DEPTH)) dut (
    .clk(clk), .res(res), .found(found), .taps(taps), .ser_ready(ser_ready),
    .ser_valid(ser_valid), .ser_dout(ser_dout), .ser_last(ser_last),
    .count(count), .full(full), .empty(empty), .overflow(overflow)
  );

  // Clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [W-1:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = W - 1; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [FL-1:0] frame_of(input logic [W-1:0] d);
`ifdef TAP_FRAME_CRC_EN
    return {d, crc8(d)};
`else
    return d;
`endif
  endfunction

  // Serial monitor: collects accepted bits, checks hold while stalled and frame contents.
  int           nbits = 0;
  int           valid_seen = 0;
  logic [FL-1:0] got = '0;
  logic         prev_hold = 1'b0;
  logic         prev_dout = 1'b0;
  logic         prev_last = 1'b0;
  logic [W-1:0] exp_w;

  always @(negedge clk) begin
    if (!res) begin
      nbits     = 0;
      prev_hold = 1'b0;
    end else begin
      if (ser_valid) valid_seen++;
      if (prev_hold) begin
        check_eq("hold_valid", ser_valid, 1);
        check_eq("hold_dout", ser_dout, prev_dout);
        check_eq("hold_last", ser_last, prev_last);
      end
      prev_hold = ser_valid && !ser_ready;
      prev_dout = ser_dout;
      prev_last = ser_last;
      if (ser_valid && ser_ready) begin
        if (nbits == 0) check_eq("frame_expected", exp_q.size() > 0, 1);
        got = {got[FL-2:0], ser_dout};
        check_eq("ser_last_pos", ser_last, nbits == FL - 1);
        if (nbits == FL - 1) begin
          nbits = 0;
          if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            check_eq("frame", got, frame_of(exp_w));
          end
        end else begin
          nbits++;
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] v, input bit accept);
    found = 1'b1;
    taps  = v;
    if (accept) exp_q.push_back(v);
    tick();
    found = 1'b0;
  endtask

  task automatic do_reset();
    res = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    res = 1'b1;
  endtask

  task automatic wait_drain(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && (exp_q.size() != 0 || ser_valid); i++) tick();
    check_eq(tag, exp_q.size(), 0);
  endtask

  initial begin
    // 1: reset values, latency, single frame
    #2;
    check_eq("rst_valid", ser_valid, 0);
    check_eq("rst_dout", ser_dout, 0);
    check_eq("rst_last", ser_last, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_ovf", overflow, 0);
    repeat (3) tick();
    res = 1'b1;
    ser_ready = 1'b1;
    push(16'hA5C3, 1);
    check_eq("lat_k_valid", ser_valid, 0);
    check_eq("lat_k_count", count, 1);
    tick();
    check_eq("lat_k1_valid", ser_valid, 1);
    check_eq("lat_k1_dout", ser_dout, 1);
    wait_drain("t1_drain", 100);
    check_eq("t1_count", count, 0);
    check_eq("t1_empty", empty, 1);

    // 2: fill with ready low, overflow on the sixth pulse, then drain in order
    ser_ready = 1'b0;
    for (int v = 1; v <= 5; v++) push(W'(v), 1);
    check_eq("t2_count", count, 4);
    check_eq("t2_full", full, 1);
    check_eq("t2_ovf0", overflow, 0);
    push(16'h0006, 0);
    check_eq("t2_ovf1", overflow, 1);
    check_eq("t2_count_hold", count, 4);
    ser_ready = 1'b1;
    wait_drain("t2_drain", 300);

    // 3: ready pattern 1,0,0,1 during frames
    ser_ready = 1'b0;
    push(16'hFFFF, 1);
    push(16'h8001, 1);
    for (int i = 0; i < 400 && (exp_q.size() != 0 || ser_valid); i++) begin
      ser_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    ser_ready = 1'b1;
    check_eq("t3_drain", exp_q.size(), 0);
    wait_drain("t3_idle", 50);

    // 4: push coinciding with the pop edge while full
    do_reset();
    ser_ready = 1'b0;
    for (int v = 1; v <= 5; v++) push(W'(v * 17), 1);
    check_eq("t4_count", count, 4);
    ser_ready = 1'b1;
    for (int i = 0; i < 50 && !ser_last; i++) tick();
    check_eq("t4_last_seen", ser_last, 1);
    tick();
    check_eq("t4_idle_valid", ser_valid, 0);
    check_eq("t4_idle_count", count, 4);
    push(16'h0066, 1);
    check_eq("t4_count_after", count, 4);
    check_eq("t4_full_after", full, 1);
    check_eq("t4_ovf", overflow, 0);
    check_eq("t4_valid", ser_valid, 1);
    wait_drain("t4_drain", 300);

    // 5: asynchronous reset mid-frame
    push(16'h1234, 1);
    for (int i = 0; i < 50 && nbits != 7; i++) tick();
    check_eq("t5_bit7", nbits, 7);
    res = 1'b0;
    #1;
    check_eq("t5_valid", ser_valid, 0);
    check_eq("t5_last", ser_last, 0);
    check_eq("t5_dout", ser_dout, 0);
    check_eq("t5_count", count, 0);
    exp_q.delete();
    repeat (2) tick();
    res = 1'b1;
    check_eq("t5_empty", empty, 1);
    check_eq("t5_ovf", overflow, 0);
    valid_seen = 0;
    repeat (40) tick();
    check_eq("t5_no_residual", valid_seen, 0);

    // 6: single word 0x0001 (CRC trailer 0x07 when enabled)
    push(16'h0001, 1);
    wait_drain("t6_drain", 100);
    check_eq("t6_empty", empty, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
